scarv_cop_ctrl: RTL and testbench

SCARV_COP_CTRL -- requirements
Module: scarv_cop_ctrl

---
 rtl/scarv_cop_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_scarv_cop_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_ctrl.sv
// -----------------------------------------------------------------------------
// scarv_cop_ctrl
//
// Instruction-sequencing controller for the SCARV co-processor. It accepts one
// instruction at a time from the CPU, latches its encoding and rs1 operand for
// the decoder, dispatches it to exactly one functional unit (PALU, MEM or
// MALU), waits for completion, abort, exception or watchdog timeout, and then
// presents a result code to the CPU until the CPU acknowledges it.
//
// Handshakes (both directions use valid/ready semantics):
//   * Request: cpu_insn_req is the valid and cop_insn_ack is the ready. A
//     transfer happens on a g_clk edge where both are high. cop_insn_ack is
//     high only while IDLE.
//   * Response: cop_insn_rsp is the valid and cpu_insn_ack is the ready. A
//     transfer happens on a g_clk edge where both are high. cop_result and
//     cop_wen are stable while cop_insn_rsp is high.
//   A response transfer returns the controller to IDLE. The next request can
//   only be accepted on a later edge, so back-to-back instructions are
//   separated by at least one idle cycle.
//
// Ports
//   g_clk, g_resetn          clock; asynchronous active-low reset
//   cpu_insn_req/cop_insn_ack  instruction request handshake
//   cpu_abort_req            abort the executing (non-memory) instruction
//   cpu_insn_enc, cpu_rs1    instruction encoding and rs1 value
//   cop_insn_rsp/cpu_insn_ack  instruction response handshake
//   cop_result               result code (SUCCESS, ABORT, BAD_INS, ...)
//   cop_wen                  GPR write enable, valid with cop_insn_rsp
//   insn_q, rs1_q            latched encoding / rs1, feeding the decoder
//   id_exception             decoder flags an illegal instruction
//   id_fu_sel                one-hot FU select {malu, mem, palu}
//   id_gpr_wb                instruction writes a GPR
//   fu_ivalid                one-hot FU dispatch, same bit order as id_fu_sel
//   fu_idone                 per-FU completion
//   mem_addr_error, mem_bus_error, mem_is_store  memory unit status
//   cpr_wb_en                CPR writeback gate, pulses on a clean completion
//   dbg_state                current FSM state, for observation only
// -----------------------------------------------------------------------------
module scarv_cop_ctrl #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        g_clk,
   input  logic        g_resetn,

   input  logic        cpu_insn_req,
   output logic        cop_insn_ack,
   input  logic        cpu_abort_req,
   input  logic [31:0] cpu_insn_enc,
   input  logic [31:0] cpu_rs1,
   output logic        cop_insn_rsp,
   input  logic        cpu_insn_ack,
   output logic [2:0]  cop_result,
   output logic        cop_wen,

   output logic [31:0] insn_q,
   output logic [31:0] rs1_q,
   input  logic        id_exception,
   input  logic [2:0]  id_fu_sel,
   input  logic        id_gpr_wb,

   output logic [2:0]  fu_ivalid,
   input  logic [2:0]  fu_idone,
   input  logic        mem_addr_error,
   input  logic        mem_bus_error,
   input  logic        mem_is_store,
   output logic        cpr_wb_en,

   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10,
      ST_BAD  = 2'b11
   } state_t;

   localparam logic [2:0] RES_SUCCESS = 3'd0;
   localparam logic [2:0] RES_ABORT   = 3'd1;
   localparam logic [2:0] RES_BAD_INS = 3'd2;
   localparam logic [2:0] RES_BAD_LAD = 3'd3;
   localparam logic [2:0] RES_BAD_SAD = 3'd4;
   localparam logic [2:0] RES_LD_ERR  = 3'd5;
   localparam logic [2:0] RES_ST_ERR  = 3'd6;
   localparam logic [2:0] RES_TIMEOUT = 3'd7;

   localparam logic [2:0] SEL_MEM = 3'b010;

   state_t      state_q, state_d;
   logic [7:0]  counter_q, counter_d;
   logic [2:0]  result_q, result_d;
   logic        gpr_wb_q, gpr_wb_d;
   logic        accept;

   // A select that is zero or has more than one bit set is as illegal as a
   // decoder-flagged exception.
   logic        sel_one_hot;
   logic        bad_insn;
   logic        is_mem;
   logic        abort_take;
   logic        fu_done;
   logic        timeout_hit;
   logic [2:0]  done_result;
   logic [7:0]  counter_inc;

   assign sel_one_hot = (id_fu_sel != 3'b000) &&
                        ((id_fu_sel & (id_fu_sel - 3'd1)) == 3'b000);
   assign bad_insn    = id_exception || !sel_one_hot;
   assign is_mem      = (id_fu_sel == SEL_MEM);

   // Memory operations cannot be abandoned half-way on the bus, so an abort
   // request is ignored while the MEM unit owns the instruction.
   assign abort_take  = cpu_abort_req && !is_mem;

   // Completion strobes from units that were not selected are ignored.
   assign fu_done     = |(fu_idone & id_fu_sel);

   assign counter_inc = (counter_q >= TIMEOUT) ? TIMEOUT : counter_q + 8'd1;

   // The watchdog fires on the edge where the counter would reach TIMEOUT,
   // so an instruction spends exactly TIMEOUT cycles in EXEC before RESP.
   assign timeout_hit = ({1'b0, counter_q} + 9'd1) >= {1'b0, TIMEOUT};

   always_comb begin
      done_result = RES_SUCCESS;
      if (mem_addr_error) begin
         done_result = mem_is_store ? RES_BAD_SAD : RES_BAD_LAD;
      end else if (mem_bus_error) begin
         done_result = mem_is_store ? RES_ST_ERR : RES_LD_ERR;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d      = state_q;
      counter_d    = counter_q;
      result_d     = result_q;
      gpr_wb_d     = gpr_wb_q;
      accept       = 1'b0;
      cop_insn_ack = 1'b0;
      cop_insn_rsp = 1'b0;
      fu_ivalid    = 3'b000;
      cpr_wb_en    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cop_insn_ack = 1'b1;
            if (cpu_insn_req) begin
               accept    = 1'b1;
               counter_d = 8'd0;
               state_d   = ST_EXEC;
            end
         end

         ST_EXEC: begin
            fu_ivalid = bad_insn ? 3'b000 : id_fu_sel;
            if (!fu_done) begin
               counter_d = counter_inc;
            end
            // Priority: exception > abort > completion > timeout.
            if (bad_insn) begin
               state_d  = ST_RESP;
               result_d = RES_BAD_INS;
               gpr_wb_d = id_gpr_wb;
            end else if (abort_take) begin
               state_d  = ST_RESP;
               result_d = RES_ABORT;
               gpr_wb_d = id_gpr_wb;
            end else if (fu_done) begin
               state_d   = ST_RESP;
               result_d  = done_result;
               gpr_wb_d  = id_gpr_wb;
               cpr_wb_en = (done_result == RES_SUCCESS);
            end else if (timeout_hit) begin
               state_d  = ST_RESP;
               result_d = RES_TIMEOUT;
               gpr_wb_d = id_gpr_wb;
            end
         end

         ST_RESP: begin
            cop_insn_rsp = 1'b1;
            if (cpu_insn_ack) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            // Unreachable encoding: recover to IDLE on the next edge.
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state_q   <= ST_IDLE;
         counter_q <= 8'd0;
         result_q  <= RES_SUCCESS;
         gpr_wb_q  <= 1'b0;
         insn_q    <= 32'd0;
         rs1_q     <= 32'd0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         result_q  <= result_d;
         gpr_wb_q  <= gpr_wb_d;
         if (accept) begin
            insn_q <= cpu_insn_enc;
            rs1_q  <= cpu_rs1;
         end
      end
   end

   assign cop_result = result_q;
   assign cop_wen    = (state_q == ST_RESP) && gpr_wb_q && (result_q == RES_SUCCESS);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_scarv_cop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scarv_cop_ctrl
//
// Directed and randomised bench for scarv_cop_ctrl. Each instruction is
// described by a scenario record; a behavioural model turns the scenario into
// the expected result code and EXEC length, which go through an expected
// queue and are checked when the response appears.
// -----------------------------------------------------------------------------
module tb_scarv_cop_ctrl;

   localparam logic [7:0] TMO = 8'd4;

   // ---------------------------------------------------------------- signals
   logic        g_clk;
   logic        g_resetn;
   logic        cpu_insn_req;
   logic        cop_insn_ack;
   logic        cpu_abort_req;
   logic [31:0] cpu_insn_enc;
   logic [31:0] cpu_rs1;
   logic        cop_insn_rsp;
   logic        cpu_insn_ack;
   logic [2:0]  cop_result;
   logic        cop_wen;
   logic [31:0] insn_q;
   logic [31:0] rs1_q;
   logic        id_exception;
   logic [2:0]  id_fu_sel;
   logic        id_gpr_wb;
   logic [2:0]  fu_ivalid;
   logic [2:0]  fu_idone;
   logic        mem_addr_error;
   logic        mem_bus_error;
   logic        mem_is_store;
   logic        cpr_wb_en;
   logic [1:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [2:0] exp_q[$];

   typedef struct {
      logic [2:0]  sel;
      bit          exc;
      int          done_cyc;   // EXEC cycle with selected idone, 0 = never
      int          abort_cyc;  // EXEC cycle with abort request, 0 = never
      bit          addr_err;
      bit          bus_err;
      bit          is_store;
      bit          gpr_wb;
      logic [31:0] enc;
      logic [31:0] rs1;
      int          hold;       // RESP cycles before the CPU acknowledges
   } scen_t;

   scarv_cop_ctrl #(.TIMEOUT(TMO)) dut (
      .g_clk          (g_clk),
      .g_resetn       (g_resetn),
      .cpu_insn_req   (cpu_insn_req),
      .cop_insn_ack   (cop_insn_ack),
      .cpu_abort_req  (cpu_abort_req),
      .cpu_insn_enc   (cpu_insn_enc),
      .cpu_rs1        (cpu_rs1),
      .cop_insn_rsp   (cop_insn_rsp),
      .cpu_insn_ack   (cpu_insn_ack),
      .cop_result     (cop_result),
      .cop_wen        (cop_wen),
      .insn_q         (insn_q),
      .rs1_q          (rs1_q),
      .id_exception   (id_exception),
      .id_fu_sel      (id_fu_sel),
      .id_gpr_wb      (id_gpr_wb),
      .fu_ivalid      (fu_ivalid),
      .fu_idone       (fu_idone),
      .mem_addr_error (mem_addr_error),
      .mem_bus_error  (mem_bus_error),
      .mem_is_store   (mem_is_store),
      .cpr_wb_en      (cpr_wb_en),
      .dbg_state      (dbg_state)
   );

   // ------------------------------------------------------- clock and reset
   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench time limit");
   end

   // ---------------------------------------------------------------- checker
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------- reference model
   // Walks the EXEC cycles in time order applying the priority rules:
   // an illegal instruction ends on the first cycle; otherwise the first
   // cycle holding an honoured abort or a completion decides, and if none
   // arrives the watchdog ends the instruction after TMO cycles.
   function automatic void model(input scen_t s, output int len, output logic [2:0] res);
      if (s.exc || $countones(s.sel) != 1) begin
         len = 1;
         res = 3'd2;
         return;
      end
      for (int k = 1; k <= int'(TMO); k++) begin
         if (k == s.abort_cyc && s.sel != 3'b010) begin
            len = k;
            res = 3'd1;
            return;
         end
         if (k == s.done_cyc) begin
            len = k;
            if (s.addr_err)     res = s.is_store ? 3'd4 : 3'd3;
            else if (s.bus_err) res = s.is_store ? 3'd6 : 3'd5;
            else                res = 3'd0;
            return;
         end
      end
      len = int'(TMO);
      res = 3'd7;
   endfunction

   function automatic scen_t mk(input logic [2:0] sel, input bit exc, input int done_cyc,
                                input int abort_cyc, input bit addr_err, input bit bus_err,
                                input bit is_store, input bit gpr_wb, input logic [31:0] enc,
                                input logic [31:0] rs1, input int hold);
      scen_t s;
      s.sel = sel;           s.exc = exc;
      s.done_cyc = done_cyc; s.abort_cyc = abort_cyc;
      s.addr_err = addr_err; s.bus_err = bus_err;
      s.is_store = is_store; s.gpr_wb = gpr_wb;
      s.enc = enc;           s.rs1 = rs1;
      s.hold = hold;
      return s;
   endfunction

   function automatic scen_t rand_scen();
      scen_t s;
      case ($urandom_range(0, 9))
         0:       s.sel = 3'b000;
         1:       s.sel = 3'b011;
         2, 3, 4: s.sel = 3'b001;
         5, 6, 7: s.sel = 3'b010;
         default: s.sel = 3'b100;
      endcase
      s.exc       = ($urandom_range(0, 7) == 0);
      s.done_cyc  = int'($urandom_range(0, 6));
      s.abort_cyc = int'($urandom_range(0, 6));
      s.addr_err  = (s.sel == 3'b010) && ($urandom_range(0, 3) == 0);
      s.bus_err   = (s.sel == 3'b010) && ($urandom_range(0, 3) == 0);
      s.is_store  = ($urandom_range(0, 1) == 1);
      s.gpr_wb    = ($urandom_range(0, 1) == 1);
      s.enc       = $urandom;
      s.rs1       = $urandom;
      s.hold      = int'($urandom_range(0, 3));
      return s;
   endfunction

   // ----------------------------------------------------------------- driver
   task automatic run_txn(input scen_t s, input string name);
      int         len;
      logic [2:0] res;
      logic [2:0] exp_res;
      logic [2:0] exp_iv;
      bit         is_mem;

      model(s, len, res);
      exp_q.push_back(res);
      is_mem = (s.sel == 3'b010);
      exp_iv = (s.exc || $countones(s.sel) != 1) ? 3'b000 : s.sel;

      @(negedge g_clk);
      cpu_insn_req   = 1'b1;
      cpu_insn_enc   = s.enc;
      cpu_rs1        = s.rs1;
      id_exception   = s.exc;
      id_fu_sel      = s.sel;
      id_gpr_wb      = s.gpr_wb;
      mem_addr_error = s.addr_err;
      mem_bus_error  = s.bus_err;
      mem_is_store   = s.is_store;
      fu_idone       = 3'b000;
      cpu_abort_req  = 1'b0;
      cpu_insn_ack   = 1'b0;
      #1;
      check({name, ".idle_ack"}, 32'(cop_insn_ack), 32'd1);
      check({name, ".idle_ivalid"}, 32'(fu_ivalid), 32'd0);

      for (int k = 1; k <= len; k++) begin
         @(negedge g_clk);
         cpu_insn_req = 1'b0;
         fu_idone     = 3'($urandom) & ~s.sel;
         if (k == s.done_cyc) fu_idone = fu_idone | s.sel;
         cpu_abort_req = (k == s.abort_cyc) || (is_mem && ($urandom_range(0, 1) == 1));
         #1;
         check({name, ".exec_ivalid"}, 32'(fu_ivalid), 32'(exp_iv));
         check({name, ".exec_ack"}, 32'(cop_insn_ack), 32'd0);
         check({name, ".exec_rsp"}, 32'(cop_insn_rsp), 32'd0);
         check({name, ".exec_wen"}, 32'(cop_wen), 32'd0);
         check({name, ".exec_cpr_wb"}, 32'(cpr_wb_en), 32'((k == len) && (res == 3'd0)));
         check({name, ".insn_q"}, insn_q, s.enc);
         check({name, ".rs1_q"}, rs1_q, s.rs1);
      end

      @(negedge g_clk);
      fu_idone      = 3'b000;
      cpu_abort_req = 1'b0;
      #1;
      exp_res = exp_q.pop_front();
      check({name, ".rsp"}, 32'(cop_insn_rsp), 32'd1);
      check({name, ".result"}, 32'(cop_result), 32'(exp_res));
      check({name, ".wen"}, 32'(cop_wen), 32'(s.gpr_wb && (exp_res == 3'd0)));
      check({name, ".resp_ivalid"}, 32'(fu_ivalid), 32'd0);
      check({name, ".resp_cpr_wb"}, 32'(cpr_wb_en), 32'd0);
      check({name, ".resp_ack"}, 32'(cop_insn_ack), 32'd0);

      for (int h = 0; h < s.hold; h++) begin
         @(negedge g_clk);
         cpu_abort_req = ($urandom_range(0, 1) == 1);
         #1;
         check({name, ".hold_rsp"}, 32'(cop_insn_rsp), 32'd1);
         check({name, ".hold_result"}, 32'(cop_result), 32'(exp_res));
         check({name, ".hold_wen"}, 32'(cop_wen), 32'(s.gpr_wb && (exp_res == 3'd0)));
      end

      // Acknowledge while a new request is already waiting: it must not be
      // taken on the same edge.
      @(negedge g_clk);
      cpu_abort_req = 1'b0;
      cpu_insn_ack  = 1'b1;
      cpu_insn_req  = 1'b1;
      cpu_insn_enc  = ~s.enc;
      cpu_rs1       = ~s.rs1;
      @(negedge g_clk);
      #1;
      check({name, ".gap_ack"}, 32'(cop_insn_ack), 32'd1);
      check({name, ".gap_rsp"}, 32'(cop_insn_rsp), 32'd0);
      check({name, ".gap_wen"}, 32'(cop_wen), 32'd0);
      check({name, ".gap_insn_q"}, insn_q, s.enc);
      check({name, ".gap_rs1_q"}, rs1_q, s.rs1);
      cpu_insn_ack = 1'b0;
      cpu_insn_req = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, ".ack"}, 32'(cop_insn_ack), 32'd1);
      check({name, ".rsp"}, 32'(cop_insn_rsp), 32'd0);
      check({name, ".wen"}, 32'(cop_wen), 32'd0);
      check({name, ".cpr_wb"}, 32'(cpr_wb_en), 32'd0);
      check({name, ".result"}, 32'(cop_result), 32'd0);
      check({name, ".ivalid"}, 32'(fu_ivalid), 32'd0);
      check({name, ".insn_q"}, insn_q, 32'd0);
      check({name, ".rs1_q"}, rs1_q, 32'd0);
      check({name, ".state"}, 32'(dbg_state), 32'd0);
   endtask

   // --------------------------------------------------------------- sequence
   initial begin
      g_resetn       = 1'b0;
      cpu_insn_req   = 1'b0;
      cpu_abort_req  = 1'b0;
      cpu_insn_enc   = 32'd0;
      cpu_rs1        = 32'd0;
      cpu_insn_ack   = 1'b0;
      id_exception   = 1'b0;
      id_fu_sel      = 3'b000;
      id_gpr_wb      = 1'b0;
      fu_idone       = 3'b000;
      mem_addr_error = 1'b0;
      mem_bus_error  = 1'b0;
      mem_is_store   = 1'b0;

      repeat (3) @(negedge g_clk);
      #1;
      check_reset_outputs("por");
      @(negedge g_clk);
      g_resetn = 1'b1;

      // PALU success, completion in the second EXEC cycle.
      run_txn(mk(3'b001, 0, 2, 0, 0, 0, 0, 0, 32'hA5A5_A5A5, 32'h1234_5678, 0), "palu_ok");
      // Store with bus error; abort requests during the op are ignored.
      run_txn(mk(3'b010, 0, 3, 1, 0, 1, 1, 0, 32'h0000_1023, 32'h8000_0000, 1), "st_buserr");
      // Load address error and store address error.
      run_txn(mk(3'b010, 0, 1, 0, 1, 1, 0, 1, 32'h0000_2003, 32'h0000_0001, 0), "ld_addrerr");
      run_txn(mk(3'b010, 0, 2, 0, 1, 0, 1, 0, 32'h0000_3023, 32'h0000_0002, 0), "st_addrerr");
      // Illegal instruction with a GPR writeback request: no write allowed.
      run_txn(mk(3'b001, 1, 1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'h0, 0), "illegal");
      // Non one-hot selects are illegal too.
      run_txn(mk(3'b000, 0, 1, 0, 0, 0, 0, 0, 32'h1111_1111, 32'h2, 0), "sel_zero");
      run_txn(mk(3'b101, 0, 1, 0, 0, 0, 0, 0, 32'h2222_2222, 32'h3, 0), "sel_multi");
      // MALU abort in the third EXEC cycle.
      run_txn(mk(3'b100, 0, 0, 3, 0, 0, 0, 1, 32'h3333_3333, 32'h4, 0), "malu_abort");
      // Abort and completion in the same cycle: abort wins.
      run_txn(mk(3'b001, 0, 2, 2, 0, 0, 0, 0, 32'h4444_4444, 32'h5, 0), "abort_vs_done");
      // Completion on the watchdog cycle wins over the timeout.
      run_txn(mk(3'b100, 0, 4, 0, 0, 0, 0, 0, 32'h5555_5555, 32'h6, 0), "done_at_tmo");
      // Watchdog timeout with no completion.
      run_txn(mk(3'b001, 0, 0, 0, 0, 0, 0, 0, 32'h6666_6666, 32'h7, 0), "timeout");

      // Reset asserted mid-EXEC with an FU busy.
      @(negedge g_clk);
      cpu_insn_req = 1'b1;
      cpu_insn_enc = 32'h7777_7777;
      cpu_rs1      = 32'h8888_8888;
      id_exception = 1'b0;
      id_fu_sel    = 3'b100;
      id_gpr_wb    = 1'b1;
      @(negedge g_clk);
      cpu_insn_req = 1'b0;
      #1;
      check("rst_mid.busy_ivalid", 32'(fu_ivalid), 32'b100);
      #2;
      g_resetn = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge g_clk);
      g_resetn = 1'b1;

      // Held response, then a GPR-writing success.
      run_txn(mk(3'b001, 0, 1, 0, 0, 0, 0, 0, 32'h9999_9999, 32'h9, 5), "held_rsp");
      run_txn(mk(3'b100, 0, 3, 0, 0, 0, 0, 1, 32'hABCD_0001, 32'hA, 2), "mv2gpr");

      for (int i = 0; i < 40; i++) begin
         run_txn(rand_scen(), "rand");
      end

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
